mem_dump: RTL

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump_pkg.sv | 21 ++
 rtl/mem_dump_uart_tx.sv | 82 ++++++++
 rtl/mem_dump.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg
//   Shared constants for the memory-dump block: address/data widths, the
//   dump FSM state encoding, and a word-alignment helper.
package mem_dump_pkg;

   localparam int ADDR_LEN = 32;
   localparam int DATA_LEN = 32;

   // Dump FSM state encoding
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_READ = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_SEND = 3'd3;
   localparam logic [2:0] ST_NEXT = 3'd4;

   // Force a byte address down to its containing 32-bit word
   function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
      return {addr[ADDR_LEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_dump_uart_tx.sv
// uart_tx
//   8N1 UART serializer with a valid/ready byte handshake.
//   Ports:
//     clk, reset       - clock, synchronous active-high reset
//     tx_valid/tx_data - byte offered by the client
//     tx_ready         - high while idle; a byte is taken when valid & ready
//     txd              - serial line, idle high
//   The 10-bit shifter holds {stop, data[7:0], start}. Its bit 0 drives txd
//   directly, and ones shift in from the top, so an idle or finished frame
//   leaves the shifter all ones and the line high without extra logic.
module uart_tx
#(
   parameter int BAUD_DIV = 868
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       txd
);

   localparam int               BAUD_W    = $clog2(BAUD_DIV);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

   logic              active_q, active_d;
   logic [9:0]        shift_q,  shift_d;
   logic [BAUD_W-1:0] baud_q,   baud_d;
   logic [3:0]        bit_q,    bit_d;

   // Next-state logic for the baud counter, bit counter and frame shifter
   always_comb begin
      active_d = active_q;
      shift_d  = shift_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      if (!active_q) begin
         if (tx_valid) begin
            active_d = 1'b1;
            shift_d  = {1'b1, tx_data, 1'b0};
            baud_d   = '0;
            bit_d    = 4'd0;
         end else begin
            shift_d  = 10'h3FF;
         end
      end else begin
         if (baud_q == BAUD_LAST) begin
            baud_d  = '0;
            shift_d = {1'b1, shift_q[9:1]};
            if (bit_q == 4'd9) begin
               // Stop bit has been held its full period; free for the next byte
               active_d = 1'b0;
               bit_d    = 4'd0;
            end else begin
               bit_d    = bit_q + 4'd1;
            end
         end else begin
            baud_d = baud_q + BAUD_W'(1);
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         shift_q  <= 10'h3FF;
         baud_q   <= '0;
         bit_q    <= 4'd0;
      end else begin
         active_q <= active_d;
         shift_q  <= shift_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
      end
   end

   assign tx_ready = ~active_q;
   assign txd      = shift_q[0];

endmodule

// File: rtl/mem_dump.sv
// mem_dump
//   Reads word_count 32-bit words from data memory starting at base_addr
//   (word aligned) and streams each word out of a UART, LSB byte first.
//   Ports:
//     clk, reset             - clock, synchronous active-high reset
//     start                  - one-cycle dump request (ignored while busy)
//     base_addr, word_count  - dump region
//     dmem_addr, dmem_re     - memory read port; dmem_data valid 1 cycle later
//     txd                    - UART line, idle high
//     busy, done             - dump in progress / one-cycle completion pulse
module mem_dump
   import mem_dump_pkg::*;
#(
   parameter int BAUD_DIV   = 868,
   parameter int WORD_CNT_W = 16
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_LEN-1:0]   base_addr,
   input  logic [WORD_CNT_W-1:0] word_count,
   output logic [ADDR_LEN-1:0]   dmem_addr,
   output logic                  dmem_re,
   input  logic [DATA_LEN-1:0]   dmem_data,
   output logic                  txd,
   output logic                  busy,
   output logic                  done
);

   logic [2:0]            state_q, state_d;
   logic [ADDR_LEN-1:0]   addr_q,  addr_d;
   logic [WORD_CNT_W-1:0] cnt_q,   cnt_d;
   logic [DATA_LEN-1:0]   word_q,  word_d;
   logic [1:0]            byte_q,  byte_d;
   logic                  re_q,    re_d;
   logic                  busy_q,  busy_d;
   logic                  done_q,  done_d;

   logic tx_valid;
   logic tx_ready;

   // Dump FSM: address/count bookkeeping, word capture and byte sequencing
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      byte_d  = byte_q;
      re_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d = word_count;
               if (word_count == '0) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  addr_d  = word_align(base_addr);
                  re_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            word_d  = dmem_data;
            byte_d  = 2'd0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            // The previous word's last frame may still be on the line; the
            // first byte simply waits for ready like the others.
            if (tx_ready) begin
               word_d = {8'h00, word_q[DATA_LEN-1:8]};
               byte_d = byte_q + 2'd1;
               if (byte_q == 2'd3) begin
                  state_d = ST_NEXT;
               end else begin
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_NEXT: begin
            if (cnt_q != WORD_CNT_W'(1)) begin
               // Fetch the next word while the last byte is still shifting out
               cnt_d   = cnt_q - WORD_CNT_W'(1);
               addr_d  = addr_q + 32'd4;
               re_d    = 1'b1;
               state_d = ST_READ;
            end else if (tx_ready) begin
               // Final word: hold here until its last stop bit is finished
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_NEXT;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         byte_q  <= 2'd0;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         re_q    <= re_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_valid  = (state_q == ST_SEND);
   assign dmem_addr = addr_q;
   assign dmem_re   = re_q;
   assign busy      = busy_q;
   assign done      = done_q;

   uart_tx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart_tx (
      .clk      (clk),
      .reset    (reset),
      .tx_valid (tx_valid),
      .tx_data  (word_q[7:0]),
      .tx_ready (tx_ready),
      .txd      (txd)
   );

endmodule
